// File: rtl/ukf_pkg.sv
// Shared constants and load-sequencer state for the UKF covariance loader.
package ukf_pkg;
  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int MAX_N   = 12;
  localparam int HDR_LSB = 0;
  localparam int HDR_W   = 8;

  typedef enum logic [1:0] {ST_HDR, ST_DIAG, ST_LOWER, ST_KICK} ld_state_e;
endpackage

// File: rtl/ukf_lane_serializer.sv
// One-beat lane buffer: holds LANES elements and hands them out lane0 first.
module ukf_lane_serializer #(
  parameter int DATA_W = ukf_pkg::DATA_W,
  parameter int LANES  = ukf_pkg::LANES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_i,
  input  logic [LANES-1:0][DATA_W-1:0]  beat_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic                          empty_o,
  output logic [DATA_W-1:0]             data_o
);
  localparam int CW = $clog2(LANES + 1);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0][DATA_W-1:0] buf_q;
  logic [CW-1:0]                cnt_q;
  logic [PW-1:0]                ptr_q;

  // Flush wins so trailing lanes of a final beat never reach the RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (load_i) begin
      buf_q <= beat_i;
      cnt_q <= CW'(LANES);
      ptr_q <= '0;
    end else if (pop_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      ptr_q <= ptr_q + PW'(1);
    end
  end

  assign empty_o = (cnt_q == '0);
  assign data_o  = buf_q[ptr_q];
endmodule

// File: rtl/ukf_cov_load_ctrl.sv
// Covariance RAM load sequencer: header, diagonal, mirrored lower triangle, then start pulse.
module ukf_cov_load_ctrl #(
  parameter int DATA_W = ukf_pkg::DATA_W,
  parameter int LANES  = ukf_pkg::LANES,
  parameter int MAX_N  = ukf_pkg::MAX_N,
  parameter int ADDR_W = 8
) (
  input  logic                    fast_clock,
  input  logic                    reset_n,
  input  logic                    wr_enable,
  input  logic [LANES*DATA_W-1:0] write_data,
  output logic                    wr_ready,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic                    ukf_busy,
  output logic                    start_ukf,
  output logic [3:0]              n_dim,
  output logic                    load_done,
  output logic                    err_dim
);
  import ukf_pkg::*;

  ld_state_e         state_q;
  logic              active_q, err_q, done_q, start_q, phase_q;
  logic [3:0]        n_q, idx_q, j_q;
  logic [ADDR_W-1:0] base_q, cbase_q;

  logic              accept, writing, hdr_ok, diag_last, row_end, last_row;
  logic              sr_load, sr_pop, sr_flush, sr_empty;
  logic [DATA_W-1:0] sr_data;
  logic [HDR_W-1:0]  hdr_n;

  assign hdr_n     = write_data[HDR_LSB +: HDR_W];
  assign hdr_ok    = (hdr_n != '0) && (hdr_n <= HDR_W'(MAX_N));
  assign accept    = wr_enable && wr_ready;
  assign writing   = !sr_empty && (state_q == ST_DIAG || state_q == ST_LOWER);
  assign diag_last = (idx_q == n_q - 4'd1);
  assign row_end   = (j_q == idx_q - 4'd1);
  assign last_row  = (idx_q == n_q - 4'd1);

  // Ready only once the buffer has fully drained, which leaves one bubble per beat.
  assign wr_ready = (state_q == ST_HDR) ? active_q
                  : ((state_q == ST_DIAG || state_q == ST_LOWER) && sr_empty);

  assign sr_load  = accept && (state_q != ST_HDR);
  assign sr_pop   = writing && (state_q == ST_DIAG || phase_q);
  assign sr_flush = writing && ((state_q == ST_DIAG && diag_last) ||
                                (state_q == ST_LOWER && phase_q && row_end && last_row));

  ukf_lane_serializer #(.DATA_W(DATA_W), .LANES(LANES)) u_ser (
    .clk_i   (fast_clock),
    .rst_ni  (reset_n),
    .load_i  (sr_load),
    .beat_i  (write_data),
    .pop_i   (sr_pop),
    .flush_i (sr_flush),
    .empty_o (sr_empty),
    .data_o  (sr_data)
  );

  // Lower elements go out twice: (i,j) on phase 0, mirror (j,i) on phase 1.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (writing) begin
      ram_we    = 1'b1;
      ram_wdata = sr_data;
      if (state_q == ST_DIAG)  ram_addr = base_q;
      else if (!phase_q)       ram_addr = base_q + ADDR_W'(j_q);
      else                     ram_addr = cbase_q + ADDR_W'(idx_q);
    end
  end

  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HDR;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      phase_q  <= 1'b0;
      n_q      <= '0;
      idx_q    <= '0;
      j_q      <= '0;
      base_q   <= '0;
      cbase_q  <= '0;
    end else begin
      active_q <= 1'b1;
      start_q  <= 1'b0;
      case (state_q)
        ST_HDR: if (accept) begin
          if (hdr_ok) begin
            n_q     <= hdr_n[3:0];
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            state_q <= ST_DIAG;
          end else begin
            err_q   <= 1'b1;
          end
        end
        ST_DIAG: if (writing) begin
          if (diag_last) begin
            if (n_q == 4'd1) begin
              state_q <= ST_KICK;
            end else begin
              state_q <= ST_LOWER;
              idx_q   <= 4'd1;
              j_q     <= '0;
              base_q  <= ADDR_W'(MAX_N);
              cbase_q <= '0;
              phase_q <= 1'b0;
            end
          end else begin
            idx_q  <= idx_q + 4'd1;
            base_q <= base_q + ADDR_W'(MAX_N + 1);
          end
        end
        ST_LOWER: if (writing) begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            if (row_end) begin
              if (last_row) begin
                state_q <= ST_KICK;
              end else begin
                idx_q   <= idx_q + 4'd1;
                base_q  <= base_q + ADDR_W'(MAX_N);
                j_q     <= '0;
                cbase_q <= '0;
              end
            end else begin
              j_q     <= j_q + 4'd1;
              cbase_q <= cbase_q + ADDR_W'(MAX_N);
            end
          end
        end
        ST_KICK: if (!ukf_busy) begin
          start_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_HDR;
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign start_ukf = start_q;
  assign n_dim     = n_q;
  assign load_done = done_q;
  assign err_dim   = err_q;
endmodule

// File: tb/tb_ukf_cov_load_ctrl.sv
// Randomized scoreboard bench for ukf_cov_load_ctrl against a matrix-level reference model.
module tb_ukf_cov_load_ctrl;
  localparam int DW = 32, LN = 4, MN = 12, AW = 8;

  logic            fast_clock = 1'b0, reset_n = 1'b0, wr_enable = 1'b0, ukf_busy = 1'b0;
  logic [LN*DW-1:0] write_data = '0;
  logic            wr_ready, ram_we, start_ukf, load_done, err_dim;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [3:0]      n_dim;

  ukf_cov_load_ctrl #(.DATA_W(DW), .LANES(LN), .MAX_N(MN), .ADDR_W(AW)) dut (
    .fast_clock(fast_clock), .reset_n(reset_n), .wr_enable(wr_enable),
    .write_data(write_data), .wr_ready(wr_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ukf_busy(ukf_busy),
    .start_ukf(start_ukf), .n_dim(n_dim), .load_done(load_done), .err_dim(err_dim)
  );

  always #5 fast_clock = ~fast_clock;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  int          checks = 0, errors = 0, exp_starts = 0, exp_n = 0, starts_seen = 0;
  logic [31:0] mem  [256];
  int          wcnt [256];
  logic [31:0] mref [256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    mref[a] = d;
  endtask

  // Monitor: every RAM write and start pulse is checked against the queued expectations.
  always @(negedge fast_clock) begin
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=addr %0d data %h required=no write", ram_addr, ram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("ram_addr", 64'(ram_addr), 64'(e.addr));
        chk("ram_wdata", 64'(ram_wdata), 64'(e.data));
      end
      mem[ram_addr] = ram_wdata;
      wcnt[ram_addr]++;
    end
    if (start_ukf) begin
      if (exp_starts == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start actual=1 required=0");
      end else begin
        chk("writes_left_at_start", 64'(exp_q.size()), 64'd0);
        chk("load_done_at_start", 64'(load_done), 64'd1);
        chk("n_dim_at_start", 64'(n_dim), 64'(exp_n));
        exp_starts--;
      end
      starts_seen++;
    end
  end

  task automatic send_beat(input logic [127:0] d, input int gap);
    int t = 0;
    write_data = d;
    wr_enable  = 1'b1;
    while (wr_ready !== 1'b1 && t < 500) begin
      @(negedge fast_clock);
      t++;
    end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout actual=no ready required=ready");
    end
    @(negedge fast_clock);
    if (gap > 0) begin
      wr_enable = 1'b0;
      repeat (gap) @(negedge fast_clock);
    end
  endtask

  // Reference: build the NxN matrix from element lists, queue the write order, then send beats.
  task automatic run_load(input int n, input bit fixed, input int gap_max, input int abort_lower);
    logic [31:0]  dv[$], lv[$];
    logic [127:0] beat;
    int           k, m;
    for (int a = 0; a < 256; a++) begin wcnt[a] = 0; mref[a] = 'x; end
    for (int d = 0; d < n; d++) dv.push_back(fixed ? 32'h40000000 : $urandom);
    for (int i = 1; i < n; i++)
      for (int j = 0; j < i; j++) lv.push_back(fixed ? 32'h3F800000 : $urandom);
    for (int d = 0; d < n; d++) push_wr(d*MN + d, dv[d]);
    k = 0;
    for (int i = 1; i < n; i++)
      for (int j = 0; j < i; j++) begin
        push_wr(i*MN + j, lv[k]);
        push_wr(j*MN + i, lv[k]);
        k++;
      end
    if (abort_lower < 0) exp_starts++;
    exp_n = n;
    beat = {$urandom, $urandom, $urandom, $urandom};
    beat[7:0] = 8'(n);
    send_beat(beat, gap_max == 0 ? 0 : $urandom_range(gap_max, 0));
    chk("n_dim_after_hdr", 64'(n_dim), 64'(n));
    chk("err_dim_after_hdr", 64'(err_dim), 64'd0);
    chk("load_done_after_hdr", 64'(load_done), 64'd0);
    for (int b = 0; b < (n + 3) / 4; b++) begin
      for (int l = 0; l < LN; l++)
        beat[l*32 +: 32] = (b*4 + l < n) ? dv[b*4 + l] : (fixed ? 32'hDEADBEEF : $urandom);
      send_beat(beat, gap_max == 0 ? 0 : $urandom_range(gap_max, 0));
    end
    m = n * (n - 1) / 2;
    for (int b = 0; b < (m + 3) / 4; b++) begin
      if (abort_lower >= 0 && b == abort_lower) break;
      for (int l = 0; l < LN; l++)
        beat[l*32 +: 32] = (b*4 + l < m) ? lv[b*4 + l] : (fixed ? 32'hDEADBEEF : $urandom);
      send_beat(beat, gap_max == 0 ? 0 : $urandom_range(gap_max, 0));
    end
    wr_enable = 1'b0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (exp_starts != 0 && t < 3000) begin
      @(negedge fast_clock);
      t++;
    end
    #1;
    chk("start_pending", 64'(exp_starts), 64'd0);
  endtask

  task automatic check_cover(input int n);
    int bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (a < MN*MN && a / MN < n && a % MN < n) begin
        if (wcnt[a] != 1 || mem[a] !== mref[a]) bad++;
      end else if (wcnt[a] != 0) bad++;
    end
    chk($sformatf("cover_n%0d_bad_cells", n), 64'(bad), 64'd0);
  endtask

  initial begin
    logic [127:0] beat;
    int n, s0, t;
    repeat (3) @(negedge fast_clock);
    chk("reset_outputs", 64'({wr_ready, ram_we, ram_addr, ram_wdata, start_ukf, n_dim, load_done, err_dim}), 64'd0);
    reset_n = 1'b1;
    @(negedge fast_clock);
    chk("hdr_ready", 64'(wr_ready), 64'd1);

    run_load(12, 1'b1, 2, -1);
    wait_start();
    check_cover(12);
    chk("load_done_n12", 64'(load_done), 64'd1);

    run_load(1, 1'b1, 2, -1);
    wait_start();
    check_cover(1);

    beat = {$urandom, $urandom, $urandom, $urandom};
    beat[7:0] = 8'h00;
    send_beat(beat, 1);
    chk("err_dim_hdr0", 64'(err_dim), 64'd1);
    chk("ready_after_bad_hdr0", 64'(wr_ready), 64'd1);
    beat[7:0] = 8'h0D;
    send_beat(beat, 1);
    wr_enable = 1'b0;
    chk("err_dim_hdr13", 64'(err_dim), 64'd1);
    chk("n_dim_kept_on_bad_hdr", 64'(n_dim), 64'd1);
    run_load(3, 1'b0, 1, -1);
    wait_start();
    check_cover(3);

    ukf_busy = 1'b1;
    n = $urandom_range(12, 2);
    run_load(n, 1'b0, 1, -1);
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge fast_clock); t++; end
    s0 = starts_seen;
    repeat (20) @(negedge fast_clock);
    #1;
    chk("no_start_while_busy", 64'(starts_seen), 64'(s0));
    chk("load_done_low_while_busy", 64'(load_done), 64'd0);
    @(negedge fast_clock);
    ukf_busy = 1'b0;
    @(negedge fast_clock);
    #1;
    chk("start_after_busy_fall", 64'(starts_seen), 64'(s0 + 1));
    repeat (5) @(negedge fast_clock);
    #1;
    chk("single_start_pulse", 64'(starts_seen), 64'(s0 + 1));
    wait_start();
    check_cover(n);

    repeat (3) begin
      n = $urandom_range(12, 1);
      run_load(n, 1'b0, 0, -1);
      wait_start();
      check_cover(n);
    end

    repeat (10) begin
      n = $urandom_range(12, 1);
      run_load(n, 1'b0, 3, -1);
      wait_start();
      check_cover(n);
    end

    run_load(12, 1'b0, 1, 5);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_starts = 0;
    #1;
    chk("midload_reset_outputs", 64'({wr_ready, ram_we, ram_addr, ram_wdata, start_ukf, n_dim, load_done, err_dim}), 64'd0);
    repeat (3) @(negedge fast_clock);
    reset_n = 1'b1;
    repeat (10) @(negedge fast_clock);
    run_load(2, 1'b0, 1, -1);
    wait_start();
    check_cover(2);

    repeat (5) @(negedge fast_clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
